// File: rtl/hermes_pkg.sv
// Shared types for the Hermes packet injector.
// State encoding and router address width.
package hermes_pkg;

    localparam int HERMES_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } hermes_inj_state_t;

endpackage

// File: rtl/hermes_packet_injector_stats.sv
// Packet, flit and stall counters for the injector.
// Instantiated only when HERMES_INJ_STATS_EN is defined.
module hermes_inj_stats (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tx_i,
    input  logic        credit_i,
    input  logic        pkt_done_i,
    output logic [31:0] pkt_count_o,
    output logic [31:0] flit_count_o,
    output logic [31:0] stall_count_o
);

    logic [31:0] pkt_q, flit_q, stall_q;

    // Free-running counters, wrap modulo 2^32
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_q   <= '0;
            flit_q  <= '0;
            stall_q <= '0;
        end else begin
            if (pkt_done_i)
                pkt_q <= pkt_q + 32'd1;
            if (tx_i && credit_i)
                flit_q <= flit_q + 32'd1;
            if (tx_i && !credit_i)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign pkt_count_o   = pkt_q;
    assign flit_count_o  = flit_q;
    assign stall_count_o = stall_q;

endmodule

// File: rtl/hermes_packet_injector.sv
// Hermes local-port packet source: header, size, payload flits.
// Optional counters under macro HERMES_INJ_STATS_EN.
module hermes_packet_injector
    import hermes_pkg::*;
#(
    parameter int FLIT_SIZE  = 32,
    parameter int MAX_SIZE_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [HERMES_ADDR_W-1:0] target_i,
    input  logic [MAX_SIZE_W-1:0]    size_i,
    input  logic                     pl_valid_i,
    output logic                     pl_ready_o,
    input  logic [FLIT_SIZE-1:0]     pl_data_i,
    output logic                     tx_o,
    input  logic                     credit_i,
    output logic [FLIT_SIZE-1:0]     data_o
`ifdef HERMES_INJ_STATS_EN
    ,
    output logic [31:0]              pkt_count_o,
    output logic [31:0]              flit_count_o,
    output logic [31:0]              stall_count_o
`endif
);

    hermes_inj_state_t          state_q, state_d;
    logic [HERMES_ADDR_W-1:0]   target_q, target_d;
    logic [MAX_SIZE_W-1:0]      size_q, size_d;
    logic [MAX_SIZE_W-1:0]      count_q, count_d;
    logic                       pl_xfer;
    logic                       pkt_end;

    assign pl_xfer = pl_valid_i && credit_i;

    // Last flit of the packet leaves this cycle
    assign pkt_end = ((state_q == SIZE) && credit_i
                      && (size_q == '0))
                  || ((state_q == PAYLOAD) && pl_xfer
                      && (count_q == MAX_SIZE_W'(1)));

    // State and latched request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            target_q <= '0;
            size_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            size_q   <= size_d;
            count_q  <= count_d;
        end
    end

    // Next state and flit outputs; header/size held until credit
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        size_d      = size_q;
        count_d     = count_q;
        req_ready_o = 1'b0;
        pl_ready_o  = 1'b0;
        tx_o        = 1'b0;
        data_o      = '0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    target_d = target_i;
                    size_d   = size_i;
                    state_d  = HEADER;
                end
            end
            HEADER: begin
                tx_o = 1'b1;
                data_o[HERMES_ADDR_W-1:0] = target_q;
                if (credit_i)
                    state_d = SIZE;
            end
            SIZE: begin
                tx_o = 1'b1;
                data_o[MAX_SIZE_W-1:0] = size_q;
                if (credit_i) begin
                    if (pkt_end) begin
                        state_d = IDLE;
                    end else begin
                        count_d = size_q;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                tx_o       = pl_valid_i;
                data_o     = pl_data_i;
                pl_ready_o = credit_i;
                if (pl_xfer) begin
                    count_d = count_q - MAX_SIZE_W'(1);
                    if (pkt_end)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef HERMES_INJ_STATS_EN
    hermes_inj_stats u_stats (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .tx_i          (tx_o),
        .credit_i      (credit_i),
        .pkt_done_i    (pkt_end),
        .pkt_count_o   (pkt_count_o),
        .flit_count_o  (flit_count_o),
        .stall_count_o (stall_count_o)
    );
`endif

endmodule

// File: tb/tb_hermes_packet_injector.sv
// Directed vector bench for hermes_packet_injector.
// Stats counters are checked when HERMES_INJ_STATS_EN is defined.
module tb_hermes_packet_injector;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] target;
    logic [15:0] size;
    logic        pl_valid;
    logic        pl_ready;
    logic [31:0] pl_data;
    logic        tx;
    logic        credit;
    logic [31:0] data;
`ifdef HERMES_INJ_STATS_EN
    logic [31:0] pkt_cnt, flit_cnt, stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rv;
        logic [15:0] tgt;
        logic [15:0] sz;
        logic        pv;
        logic [31:0] pd;
        logic        cr;
        logic        etx;
        logic [31:0] ed;
        logic        eplr;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    hermes_packet_injector #(
        .FLIT_SIZE  (32),
        .MAX_SIZE_W (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .target_i    (target),
        .size_i      (size),
        .pl_valid_i  (pl_valid),
        .pl_ready_o  (pl_ready),
        .pl_data_i   (pl_data),
        .tx_o        (tx),
        .credit_i    (credit),
        .data_o      (data)
`ifdef HERMES_INJ_STATS_EN
        ,
        .pkt_count_o   (pkt_cnt),
        .flit_count_o  (flit_cnt),
        .stall_count_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(
        logic rv, logic [15:0] tgt, logic [15:0] sz,
        logic pv, logic [31:0] pd, logic cr,
        logic etx, logic [31:0] ed, logic eplr, logic err);
        vec_t r;
        r.rv = rv; r.tgt = tgt; r.sz = sz;
        r.pv = pv; r.pd = pd; r.cr = cr;
        r.etx = etx; r.ed = ed; r.eplr = eplr; r.err = err;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    // Drive one cycle of inputs mid-cycle, check settled outputs
    task automatic step(string tag, vec_t t);
        @(negedge clk);
        req_valid = t.rv;
        target    = t.tgt;
        size      = t.sz;
        pl_valid  = t.pv;
        pl_data   = t.pd;
        credit    = t.cr;
        #1;
        chk({tag, " tx"}, 32'(tx), 32'(t.etx));
        chk({tag, " data"}, data, t.ed);
        chk({tag, " pl_ready"}, 32'(pl_ready), 32'(t.eplr));
        chk({tag, " req_ready"}, 32'(req_ready), 32'(t.err));
    endtask

    task automatic run_tbl(string tag);
        foreach (tbl[i])
            step($sformatf("%s[%0d]", tag, i), tbl[i]);
        tbl.delete();
    endtask

    localparam logic [31:0] A = 32'hA000_000A;
    localparam logic [31:0] B = 32'hB000_000B;
    localparam logic [31:0] C = 32'hC000_000C;
    localparam logic [31:0] D = 32'hD000_000D;
    localparam logic [31:0] E = 32'hE000_000E;
    localparam logic [31:0] F = 32'hF000_000F;
    localparam logic [31:0] G = 32'h1234_5678;
    localparam logic [31:0] H = 32'h8765_4321;
    localparam logic [31:0] X = 32'h5555_AAAA;

    initial begin
        rst_n = 1'b0;
        req_valid = 0; target = 0; size = 0;
        pl_valid = 0; pl_data = 0; credit = 0;
        #12;
        chk("reset tx", 32'(tx), 0);
        chk("reset req_ready", 32'(req_ready), 1);
        chk("reset pl_ready", 32'(pl_ready), 0);
        chk("reset data", data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic packet, credit high throughout
        tbl.push_back(v(1, 16'h0102, 3, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h102, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h3, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, A, 1, 1, A, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, B, 1, 1, B, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, C, 1, 1, C, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // Backpressure: 4 stalled header cycles, 2 mid-payload
        tbl.push_back(v(1, 16'h0304, 2, 0, 0, 1, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 16'hFFFF, 9, 1, X, 0,
                            1, 32'h304, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h304, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h2, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, D, 1, 1, D, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, E, 0, 1, E, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, E, 0, 1, E, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, E, 1, 1, E, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // Zero-size packet; payload offered outside packet ignored
        tbl.push_back(v(1, 16'h0A0B, 0, 1, X, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, X, 1, 1, 32'h0A0B, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, X, 1, 1, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, X, 1, 0, 0, 0, 1));
        // Payload starvation for 3 cycles
        tbl.push_back(v(1, 16'h0001, 2, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h2, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 0, 0, 0, X, 1, 0, X, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, F, 1, 1, F, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, G, 1, 1, G, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        run_tbl("vec");

        // Async reset after 2 of 5 payload flits
        tbl.push_back(v(1, 16'h0505, 5, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h505, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h5, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, A, 1, 1, A, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, B, 1, 1, B, 1, 0));
        run_tbl("prerst");
        @(negedge clk);
        pl_valid = 1; pl_data = X; credit = 1;
        #1;
        chk("midpkt tx", 32'(tx), 1);
        rst_n = 1'b0;
        #1;
        chk("asyncrst tx", 32'(tx), 0);
        chk("asyncrst req_ready", 32'(req_ready), 1);
        chk("asyncrst pl_ready", 32'(pl_ready), 0);
        chk("asyncrst data", data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tbl.push_back(v(1, 16'h0707, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h707, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, H, 1, 1, H, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        run_tbl("postrst");

`ifdef HERMES_INJ_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("stats rst pkt", pkt_cnt, 0);
        chk("stats rst flit", flit_cnt, 0);
        chk("stats rst stall", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tbl.push_back(v(1, 16'h0011, 2, 0, 0, 1, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h11, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h11, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h2, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, C, 1, 1, C, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, D, 1, 1, D, 1, 0));
        tbl.push_back(v(1, 16'h0022, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h22, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        run_tbl("stats");
        chk("stats pkt", pkt_cnt, 2);
        chk("stats flit", flit_cnt, 6);
        chk("stats stall", stall_cnt, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
